// File: rtl/pic_priority_isr_if.sv
// pic_priority_isr_if
// Bundles every non-clock signal between the 8259A priority/in-service
// stage and its environment (request register, command decoder, CPU bus).
//
// Signals (direction as seen by the slave = the priority stage):
//   irr_status[7:0]          in   pending requests from the request register
//   imr[7:0]                 in   interrupt mask, 1 masks that IR
//   inta_n                   in   CPU acknowledge, active low
//   vector_base[4:0]         in   vector bits T7..T3
//   aeoi                     in   auto-EOI mode
//   rotate_mode              in   automatic rotation on EOI
//   eoi_cmd                  in   one-cycle EOI command strobe
//   eoi_specific             in   1 = specific EOI, 0 = non-specific
//   eoi_level[2:0]           in   target level for specific EOI
//   int_out                  out  interrupt request to CPU
//   inta_count[1:0]          out  acknowledge pulse count (0/1/2)
//   current_service_int[2:0] out  level being acknowledged
//   isr[7:0]                 out  in-service register
//   data_out[7:0]            out  vector byte
//   data_oe                  out  data_out valid / bus drive enable
interface pic_priority_isr_if;
    logic [7:0] irr_status;
    logic [7:0] imr;
    logic       inta_n;
    logic [4:0] vector_base;
    logic       aeoi;
    logic       rotate_mode;
    logic       eoi_cmd;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic       int_out;
    logic [1:0] inta_count;
    logic [2:0] current_service_int;
    logic [7:0] isr;
    logic [7:0] data_out;
    logic       data_oe;

    modport slave (
        input  irr_status, imr, inta_n, vector_base, aeoi, rotate_mode,
               eoi_cmd, eoi_specific, eoi_level,
        output int_out, inta_count, current_service_int, isr, data_out, data_oe
    );

    modport master (
        output irr_status, imr, inta_n, vector_base, aeoi, rotate_mode,
               eoi_cmd, eoi_specific, eoi_level,
        input  int_out, inta_count, current_service_int, isr, data_out, data_oe
    );
endinterface

// File: rtl/pic_priority_isr.sv
// pic_priority_isr
// Priority resolver and in-service register of an 8259A-style interrupt
// controller. Masks pending requests, picks the winner under fixed or
// rotating priority, applies the fully nested rule against the ISR, raises
// INT, runs the two-pulse INTA sequence, drives the vector byte, and handles
// EOI / auto-EOI with optional priority rotation.
//
// Ports:
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   bus   pic_priority_isr_if.slave (request/mask/ack/EOI inputs, INT,
//         inta_count, current_service_int, isr, vector outputs)
//
// Parameter:
//   RESET_LOWEST  IR level holding lowest priority after reset
//                 (7 means IR0 is highest).
module pic_priority_isr #(
    parameter logic [2:0] RESET_LOWEST = 3'd7
) (
    input  logic                  clk,
    input  logic                  rst,
    pic_priority_isr_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK1 = 2'd1,
        ACK2 = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       int_out_q, int_out_d;
    logic [1:0] inta_count_q, inta_count_d;
    logic [2:0] csi_q, csi_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] data_out_q, data_out_d;
    logic       data_oe_q, data_oe_d;
    logic [2:0] lowest_pri_q, lowest_pri_d;
    logic       inta_prev_q, inta_prev_d;
    logic       spurious_q, spurious_d;

    logic       fall;
    logic       rise;
    logic [7:0] cand;
    logic       win_valid;
    logic [2:0] win_lvl;
    logic       top_valid;
    logic [2:0] top_lvl;
    logic       eligible;
    logic [2:0] eoi_lvl;
    logic       eoi_hit;

    // Rotate the request vector so the highest-priority level lands in bit 0,
    // then take the lowest set bit and rotate the index back.
    // Returns {found, level}.
    function automatic logic [3:0] pick_highest(input logic [7:0] req,
                                                input logic [2:0] lowest);
        logic [2:0]  shift;
        logic [15:0] dbl;
        logic [3:0]  result;
        shift  = lowest + 3'd1;
        dbl    = {req, req} >> shift;
        result = 4'b0;
        for (int i = 7; i >= 0; i--) begin
            if (dbl[i]) begin
                result = {1'b1, shift + 3'(i)};
            end
        end
        return result;
    endfunction

    // Priority rank of a level: 0 is highest, 7 is lowest.
    function automatic logic [2:0] rank_of(input logic [2:0] lvl,
                                           input logic [2:0] lowest);
        return lvl - lowest - 3'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            int_out_q    <= 1'b0;
            inta_count_q <= 2'd0;
            csi_q        <= 3'd0;
            isr_q        <= 8'd0;
            data_out_q   <= 8'd0;
            data_oe_q    <= 1'b0;
            lowest_pri_q <= RESET_LOWEST;
            inta_prev_q  <= 1'b1;
            spurious_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            int_out_q    <= int_out_d;
            inta_count_q <= inta_count_d;
            csi_q        <= csi_d;
            isr_q        <= isr_d;
            data_out_q   <= data_out_d;
            data_oe_q    <= data_oe_d;
            lowest_pri_q <= lowest_pri_d;
            inta_prev_q  <= inta_prev_d;
            spurious_q   <= spurious_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        int_out_d    = 1'b0;
        inta_count_d = inta_count_q;
        csi_d        = csi_q;
        isr_d        = isr_q;
        data_out_d   = data_out_q;
        data_oe_d    = data_oe_q;
        lowest_pri_d = lowest_pri_q;
        inta_prev_d  = bus.inta_n;
        spurious_d   = spurious_q;

        fall = inta_prev_q & ~bus.inta_n;
        rise = ~inta_prev_q & bus.inta_n;

        cand = bus.irr_status & ~bus.imr;
        {win_valid, win_lvl} = pick_highest(cand, lowest_pri_q);
        {top_valid, top_lvl} = pick_highest(isr_q, lowest_pri_q);

        // Fully nested: the winner must strictly outrank every in-service level.
        eligible = win_valid &&
                   (!top_valid ||
                    (rank_of(win_lvl, lowest_pri_q) < rank_of(top_lvl, lowest_pri_q)));

        // EOI is applied before any ISR set below, so a set of the same bit wins.
        // With an empty ISR top_lvl is 0 and isr_q[0] is 0, so no hit.
        eoi_lvl = bus.eoi_specific ? bus.eoi_level : top_lvl;
        eoi_hit = bus.eoi_cmd && isr_q[eoi_lvl];
        if (eoi_hit) begin
            isr_d[eoi_lvl] = 1'b0;
            if (bus.rotate_mode) begin
                lowest_pri_d = eoi_lvl;
            end
        end

        case (state_q)
            IDLE: begin
                int_out_d = eligible && !fall;
                if (fall) begin
                    inta_count_d = 2'd1;
                    state_d      = ACK1;
                    // A request withdrawn since INT was raised is answered
                    // like a spurious acknowledge (IR7 vector, no ISR set).
                    if (int_out_q && win_valid) begin
                        csi_d          = win_lvl;
                        isr_d[win_lvl] = 1'b1;
                        spurious_d     = 1'b0;
                    end else begin
                        csi_d      = 3'd7;
                        spurious_d = 1'b1;
                    end
                end
            end
            ACK1: begin
                if (fall) begin
                    inta_count_d = 2'd2;
                    data_out_d   = {bus.vector_base, csi_q};
                    data_oe_d    = 1'b1;
                    state_d      = ACK2;
                end
            end
            ACK2: begin
                if (rise) begin
                    data_oe_d    = 1'b0;
                    inta_count_d = 2'd0;
                    spurious_d   = 1'b0;
                    state_d      = IDLE;
                    // Auto-EOI rotation overrides a same-cycle EOI rotation.
                    if (bus.aeoi && !spurious_q) begin
                        isr_d[csi_q] = 1'b0;
                        if (bus.rotate_mode) begin
                            lowest_pri_d = csi_q;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.int_out             = int_out_q;
    assign bus.inta_count          = inta_count_q;
    assign bus.current_service_int = csi_q;
    assign bus.isr                 = isr_q;
    assign bus.data_out            = data_out_q;
    assign bus.data_oe             = data_oe_q;

endmodule

// File: doc/pic_priority_isr.md
Name: pic_priority_isr

Overview:
- Stage directly downstream of the 8259A interrupt request register.
- Masks the request status, resolves priority (fixed or rotating), and raises INT toward the CPU.
- Runs the two-pulse INTA acknowledge sequence, maintains the in-service register (ISR), drives the vector byte, and handles EOI and auto-EOI.
- Feeds back inta_count and current_service_int so the request register can clear the bit being serviced.

Parameters:
- RESET_LOWEST, 7, IR level holding lowest priority after reset (7 means IR0 highest).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- irr_status  in  8  pending requests from the request register
- imr  in  8  interrupt mask; 1 masks that IR
- inta_n  in  1  CPU acknowledge, active low; sampled on clk
- vector_base  in  5  vector bits T7..T3
- aeoi  in  1  auto-EOI mode
- rotate_mode  in  1  automatic rotation on EOI
- eoi_cmd  in  1  one-cycle EOI command strobe
- eoi_specific  in  1  1 = specific EOI, 0 = non-specific
- eoi_level  in  3  target level for specific EOI
- int_out  out  1  interrupt request to CPU
- inta_count  out  2  acknowledge pulse count: 0 idle, 1 after first INTA, 2 after second
- current_service_int  out  3  level being acknowledged
- isr  out  8  in-service register
- data_out  out  8  vector byte
- data_oe  out  1  data_out valid / bus drive enable

Behaviour:
- Reset values:
  - Outputs: int_out=0, inta_count=0, current_service_int=0, isr=0, data_out=0, data_oe=0.
  - Internal: lowest_pri=RESET_LOWEST, inta_prev=1, state=IDLE.
  - Reset mid-sequence aborts the sequence; no ISR bit survives.
- Priority order: level (lowest_pri+1) mod 8 is highest, then ascending with wrap-around; lowest_pri is lowest.
- cand = irr_status & ~imr. winner = highest-priority set bit of cand.
- Fully nested rule: a request is eligible only if winner ranks strictly above every set ISR bit. An equal or lower level is held off.
- int_out is registered: it is 1 on the edge after eligibility holds in IDLE, and 0 outside IDLE.
- Edge detection: fall = inta_prev & ~inta_n; rise = ~inta_prev & inta_n. inta_prev is updated every cycle.
- FSM:
  - IDLE:
    - On fall with int_out=1: current_service_int<=winner (evaluated that cycle), isr[winner]<=1, inta_count<=1, int_out<=0, go ACK1.
    - On fall with int_out=0 (spurious): current_service_int<=7, inta_count<=1, no ISR change, go ACK1 with a spurious flag set.
  - ACK1:
    - On fall: inta_count<=2, data_out<={vector_base, current_service_int}, data_oe<=1, go ACK2.
    - Other edges: ignored.
  - ACK2:
    - data_oe stays 1 while inta_n is low.
    - On rise: data_oe<=0, inta_count<=0, go IDLE.
    - If aeoi=1 and not spurious: isr[current_service_int]<=0 on the same edge. If rotate_mode=1 also, lowest_pri<=current_service_int.
- EOI (accepted in any state, on the eoi_cmd cycle):
  - Non-specific: clears the highest-priority set ISR bit.
  - Specific: clears isr[eoi_level].
  - If rotate_mode=1, lowest_pri<=cleared level.
  - ISR empty (or the specific bit already 0): no-op, no rotation.
- Same-cycle EOI and ISR set (IDLE fall): the EOI clear applies first, then the set. If both target the same bit, the set wins.
- Same-cycle EOI and AEOI clear: both clears apply. Rotation takes the AEOI level.
- Masking a level while it is in service does not clear its ISR bit.
- inta_count never exceeds 2. It is 1 for exactly the interval between first and second falls.

Test Plan:
- Reset, irr_status=8'h24, imr=0, inta pulses ×2 -> int_out=1 one cycle later. After first fall: isr=8'h04, current_service_int=2, inta_count=1. After second fall with vector_base=5'h11: data_out=8'h8A, data_oe=1, inta_count=2. After rise: data_oe=0, inta_count=0.
- isr=8'h04, irr_status=8'h10 -> int_out stays 0. Then irr_status=8'h01 -> int_out=1 (IR0 preempts).
- Non-specific EOI with isr=8'h05 -> isr=8'h04. Specific EOI level 2 -> isr=0. Specific EOI on level 6 with isr=0 -> unchanged.
- rotate_mode=1, service IR3, non-specific EOI -> lowest_pri=3. Then irr_status=8'h11 -> winner IR4.
- aeoi=1, acknowledge IR5 -> isr=8'h20 during ACK1/ACK2, isr=0 after final rise, no eoi_cmd needed.
- Spurious fall with int_out=0 -> inta_count=1, current_service_int=7, vector {base,3'b111}, isr unchanged. rst asserted in ACK2 -> all outputs at reset values next edge.
